dmem_responder: RTL and testbench

//  Memory-side responder for the pipeline's data-memory port: accepts load/store requests (address, write data, byte strobes),

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_bytemerge.sv | 20 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, lane/counter widths and the captured request bundle.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/dmem_bytemerge.sv
// Byte-lane merge of store data into the old word.
// Lanes with strobe clear keep their previous contents.
module dmem_bytemerge
  import dmem_pkg::*;
(
  input  logic [31:0]      old_word,
  input  logic [31:0]      wdata,
  input  logic [LANES-1:0] wstrb,
  output logic [31:0]      merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (wstrb[i])
        merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array, programmable wait states, one-cycle response.
// Optional DMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WL = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WL);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  req_t             cap, cur;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [31:0]      merged;
  logic             acc, enter_resp, bad, commit;

  assign req_ready  = (state == S_IDLE);
  assign acc        = req_valid & req_ready;
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid & bad;

  // In IDLE the live request is used so a zero-wait access reads on accept.
  always_comb begin
    cur = cap;
    if (state == S_IDLE) begin
      cur.write = req_write;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
      cur.wstrb = req_wstrb;
    end
  end

  assign idx = cur.addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = (cur.addr[1:0] != 2'b00);
  logic unused;
  assign unused = ^cur.addr[31:AW+2];
`else
  assign bad = 1'b0;
  logic unused;
  assign unused = ^{cur.addr[31:AW+2], cur.addr[1:0]};
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          if (WAIT_CYCLES == 0) begin
            state_nx   = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nx   = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap        <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (acc)
        cap <= cur;
      if (enter_resp && !cur.write)
        resp_rdata <= bad ? 32'h0 : mem[idx];
    end
  end

  dmem_bytemerge u_merge (
    .old_word (mem[idx]),
    .wdata    (cur.wdata),
    .wstrb    (cur.wstrb),
    .merged   (merged)
  );

  // Array is deliberately not reset; commit happens on the edge leaving RESP.
  assign commit = (state == S_RESP) & cur.write & ~bad;

  always_ff @(posedge clk) begin
    if (commit)
      mem[idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a
// zero-wait instance; expected responses are queued at issue and popped on response.
module tb_dmem_responder;

  localparam int WA = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_wstrb = '0;
  logic        a_ready, a_rvalid, a_err;
  logic [31:0] a_rdata;

  logic        b_valid = 1'b0, b_write = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_wstrb = '0;
  logic        b_ready, b_rvalid, b_err;
  logic [31:0] b_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(WA)) dut (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];
  logic [31:0] last_a = '0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  int          obs_lat;
  logic        obs_r1, obs_v2, obs_e2, obs_err;
  logic [31:0] obs_rd;

  function automatic logic bad(input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] m;
    m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  // Drives one request on the WAIT_CYCLES=2 instance and records what came back.
  task automatic issue_a(input logic w, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st,
                         input bit noise);
    exp_t e;
    int idx;
    logic [31:0] old;
    idx = int'(addr[11:2]);
    @(negedge clk);
    for (int i = 0; i < 50 && a_ready !== 1'b1; i++) @(negedge clk);
    if (w) begin
      old = mdl_a.exists(idx) ? mdl_a[idx] : 32'h0;
      if (!bad(addr)) mdl_a[idx] = merge(old, wd, st);
      e.rd = last_a;
    end else begin
      e.rd = bad(addr) ? 32'h0 : (mdl_a.exists(idx) ? mdl_a[idx] : 32'h0);
      last_a = e.rd;
    end
    e.err = bad(addr);
    sb_a.push_back(e);
    a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = wd; a_wstrb = st;
    @(posedge clk); #1;
    a_valid = noise;
    if (noise) begin
      a_write = 1'b1; a_addr = 32'h80; a_wdata = 32'h12345678; a_wstrb = 4'hF;
    end
    obs_lat = -1; obs_r1 = 1'bx; obs_rd = 'x; obs_err = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) obs_r1 = a_ready;
      if (a_rvalid === 1'b1) begin
        obs_lat = c; obs_rd = a_rdata; obs_err = a_err;
        break;
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
    obs_v2 = a_rvalid;
    obs_e2 = a_err;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (a_ready !== 1'b1 || a_rvalid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               a_ready, a_rvalid, a_rdata, a_err);
    end
    n_chk++;
    if (b_ready !== 1'b1 || b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state0: ready=%b valid=%b rdata=%h required 1 0 00000000",
               b_ready, b_rvalid, b_rdata);
    end
    rst = 1'b1;
    last_a = '0;
  endtask

  task automatic test_store_load;
    exp_t e;
    issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_lat !== WA + 1 || obs_r1 !== 1'b0 || obs_v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL store_timing: lat=%0d ready_after=%b valid_next=%b required %0d 0 0",
               obs_lat, obs_r1, obs_v2, WA + 1);
    end
    n_chk++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      n_fail++;
      $display("FAIL store_resp: rdata=%h err=%b required %h %b", obs_rd, obs_err, e.rd, e.err);
    end
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_lat !== WA + 1 || obs_rd !== e.rd || obs_rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_10: lat=%0d rdata=%h required %0d DEADBEEF", obs_lat, obs_rd, WA + 1);
    end
  endtask

  task automatic test_strobe;
    exp_t e;
    issue_a(1'b1, 32'h30, 32'h11223344, 4'hF, 1'b0);
    void'(sb_a.pop_front());
    issue_a(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_rd !== e.rd) begin
      n_fail++;
      $display("FAIL strobe_store_rdata_hold: rdata=%h required %h", obs_rd, e.rd);
    end
    issue_a(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 1'b0);
    void'(sb_a.pop_front());
    issue_a(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_rd !== e.rd || obs_rd !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL strobe_merge: rdata=%h required 11BB33DD", obs_rd);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int extra;
    issue_a(1'b1, 32'h40, 32'h0BADF00D, 4'hF, 1'b0);
    void'(sb_a.pop_front());
    issue_a(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    void'(sb_a.pop_front());
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h40;
    a_wdata = 32'hFFFFFFFF; a_wstrb = 4'hF;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_ready !== 1'b1 || a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b valid=%b rdata=%h required 1 0 00000000",
               a_ready, a_rvalid, a_rdata);
    end
    rst = 1'b1;
    last_a = '0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rvalid !== 1'b0) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL reset_no_resp: pulses=%0d required 0", extra);
    end
    issue_a(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_rd !== e.rd || obs_rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL reset_abandon_store: rdata=%h required 0BADF00D", obs_rd);
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    int extra;
    issue_a(1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 1'b0);
    void'(sb_a.pop_front());
    issue_a(1'b1, 32'h1000, 32'h00000055, 4'hF, 1'b1);
    void'(sb_a.pop_front());
    n_chk++;
    if (obs_lat !== WA + 1 || obs_v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timing: lat=%0d valid_next=%b required %0d 0", obs_lat, obs_v2, WA + 1);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_rvalid !== 1'b0) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_ignored: pulses=%0d required 0", extra);
    end
    issue_a(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_rd !== e.rd || obs_rd !== 32'h00000055) begin
      n_fail++;
      $display("FAIL wrap_load: rdata=%h required 00000055", obs_rd);
    end
    issue_a(1'b0, 32'h80, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_rd !== e.rd || obs_rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL busy_not_written: rdata=%h required CAFEF00D", obs_rd);
    end
  endtask

  task automatic test_align;
    exp_t e;
    issue_a(1'b1, 32'h20, 32'h01020304, 4'hF, 1'b0);
    void'(sb_a.pop_front());
    issue_a(1'b1, 32'h22, 32'h99887766, 4'hF, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_err !== e.err || obs_e2 !== 1'b0) begin
      n_fail++;
      $display("FAIL align_store_err: err=%b err_next=%b required %b 0", obs_err, obs_e2, e.err);
    end
    issue_a(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
`ifdef DMEM_ALIGN_CHECK_EN
    if (obs_rd !== e.rd || obs_rd !== 32'h01020304) begin
`else
    if (obs_rd !== e.rd || obs_rd !== 32'h99887766) begin
`endif
      n_fail++;
      $display("FAIL align_word20: rdata=%h required %h", obs_rd, e.rd);
    end
    issue_a(1'b0, 32'h21, 32'h0, 4'h0, 1'b0);
    e = sb_a.pop_front();
    n_chk++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      n_fail++;
      $display("FAIL align_load: rdata=%h err=%b required %h %b", obs_rd, obs_err, e.rd, e.err);
    end
  endtask

  // Zero-wait instance with req_valid held high: accept every other edge.
  task automatic test_back_to_back;
    exp_t e;
    int bad_hs;
    int bad_rd;
    bad_hs = 0;
    bad_rd = 0;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_write = (ph == 0);
      b_wstrb = 4'hF;
      for (int k = 0; k < 8; k++) begin
        if (b_ready !== ((k % 2) == 0) || b_rvalid !== ((k % 2) == 1))
          bad_hs++;
        if ((k % 2) == 1 && ph == 1 && b_rvalid === 1'b1) begin
          e = sb_b.pop_front();
          if (b_rdata !== e.rd) bad_rd++;
        end
        if ((k % 2) == 0) begin
          b_addr = 32'(k * 2);
          b_wdata = 32'hB0B00000 | 32'(k);
          if (ph == 0) begin
            mdl_b[k / 2] = b_wdata;
          end else begin
            e.rd = mdl_b[k / 2];
            e.err = 1'b0;
            sb_b.push_back(e);
          end
        end
        @(negedge clk);
      end
      b_valid = 1'b0;
    end
    n_chk++;
    if (bad_hs != 0) begin
      n_fail++;
      $display("FAIL b2b_handshake: wrong_cycles=%0d required 0", bad_hs);
    end
    n_chk++;
    if (bad_rd != 0 || sb_b.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_rdata: wrong=%0d pending=%0d required 0 0", bad_rd, sb_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_strobe();
    test_reset_mid();
    test_wrap();
    test_align();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
